// File: rtl/pretrigger_ring_buffer.sv
// Pre-trigger capture buffer: records every sample into a circular history RAM and, on a
// trigger, streams back-history + trigger sample + post samples out as one valid/ready frame.
module pretrigger_ring_buffer #(
  parameter int WIDTH                   = 128,
  parameter int DEPTH                   = 128,
  parameter int MAX_BACK_LEN            = 40,
  parameter int MAX_POST_LEN            = 64,
  parameter int ALMOST_FULL_ASSERT_RATE = 50,
  localparam int BW                     = $clog2(MAX_BACK_LEN + 1),
  localparam int PLW                    = $clog2(MAX_POST_LEN + 1)
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VALID,
  input  logic             TRIGGER,
  input  logic [BW-1:0]    BACK_LEN,
  input  logic [PLW-1:0]   POST_LEN,
  output logic [WIDTH-1:0] DOUT,
  output logic             DOUT_VALID,
  input  logic             DOUT_READY,
  output logic             DOUT_LAST,
  output logic             BUSY,
  output logic             BUFF_ALMOST_FULL,
  output logic             TRIG_DROPPED,
  output logic             OVERFLOW,
  output logic [1:0]       DBG_STATE
);

  localparam int AW     = $clog2(DEPTH);
  localparam int PW     = AW + 1;
  localparam int RW     = $clog2(MAX_BACK_LEN + MAX_POST_LEN + 2);
  localparam int AF_THR = DEPTH * ALMOST_FULL_ASSERT_RATE / 100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DUMMY = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [AW:0]      r_fill;
  logic [RW-1:0]    r_remaining;

  logic [WIDTH-1:0] r_skid_data0;
  logic [WIDTH-1:0] r_skid_data1;
  logic             r_skid_v0;
  logic             r_skid_v1;
  logic             r_skid_last0;
  logic             r_skid_last1;

  logic             r_trig_dropped;
  logic             r_overflow;

  logic             w_trig_q;
  logic             w_start;
  logic             w_pop;
  logic             w_done;
  logic             w_issue;
  logic             w_issue_last;
  logic             w_overflow_evt;
  logic [PW-1:0]    w_backlog;
  logic [AW:0]      w_back_req;
  logic [AW:0]      w_back_eff;
  logic [PLW-1:0]   w_post_eff;
  logic [WIDTH-1:0] w_rd_word;

  assign w_trig_q   = DIN_VALID & TRIGGER;
  assign w_start    = (r_state == S_IDLE) & w_trig_q;
  assign w_backlog  = r_wr_ptr - r_rd_ptr;
  assign w_back_req = (AW+1)'(BACK_LEN);
  assign w_rd_word  = r_mem[r_rd_ptr[AW-1:0]];

  // Output handshake: a word transfers on any cycle with DOUT_VALID && DOUT_READY. Once
  // DOUT_VALID rises, DOUT/DOUT_LAST hold until that transfer; the only exception is an
  // overflow abort, which replaces the pending word with the zero terminator word.
  assign w_pop  = r_skid_v0 & DOUT_READY;
  assign w_done = w_pop & r_skid_last0;

  // Fill excludes the trigger sample itself, so a trigger on the first sample yields back=0.
  always_comb begin
    w_back_eff = w_back_req;
    if (w_back_eff > r_fill) begin
      w_back_eff = r_fill;
    end
    if (w_back_eff > (AW+1)'(MAX_BACK_LEN)) begin
      w_back_eff = (AW+1)'(MAX_BACK_LEN);
    end
    w_post_eff = POST_LEN;
    if (POST_LEN > PLW'(MAX_POST_LEN)) begin
      w_post_eff = PLW'(MAX_POST_LEN);
    end
  end

  // The skid admits a new read only while its second slot is empty, so the RAM read
  // enable never depends combinationally on DOUT_READY.
  assign w_issue = (r_state == S_READ) && (r_remaining != '0) &&
                   (r_rd_ptr != r_wr_ptr) && !r_skid_v1;
  assign w_issue_last = (r_remaining == RW'(1));

  assign w_overflow_evt = (r_state == S_READ) && DIN_VALID && !w_done &&
                          ((r_wr_ptr + PW'(1) - r_rd_ptr) == PW'(DEPTH));

  always_ff @(posedge CLK) begin
    if (DIN_VALID) begin
      r_mem[r_wr_ptr[AW-1:0]] <= DIN;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fill      <= '0;
      r_remaining <= '0;
    end else begin
      if (DIN_VALID) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
        if (r_fill != (AW+1)'(DEPTH)) begin
          r_fill <= r_fill + (AW+1)'(1);
        end
      end
      if (w_start) begin
        r_rd_ptr    <= r_wr_ptr - w_back_eff;
        r_remaining <= RW'(w_back_eff) + RW'(1) + RW'(w_post_eff);
      end else if (w_issue) begin
        r_rd_ptr    <= r_rd_ptr + PW'(1);
        r_remaining <= r_remaining - RW'(1);
      end
    end
  end

  // Two-entry output skid; slot 0 drives the output pins directly.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_skid_data0 <= '0;
      r_skid_data1 <= '0;
      r_skid_v0    <= 1'b0;
      r_skid_v1    <= 1'b0;
      r_skid_last0 <= 1'b0;
      r_skid_last1 <= 1'b0;
    end else if (w_overflow_evt) begin
      r_skid_data0 <= '0;
      r_skid_v0    <= 1'b1;
      r_skid_last0 <= 1'b1;
      r_skid_v1    <= 1'b0;
      r_skid_last1 <= 1'b0;
    end else begin
      case ({w_pop, w_issue})
        2'b01: begin
          if (!r_skid_v0) begin
            r_skid_data0 <= w_rd_word;
            r_skid_last0 <= w_issue_last;
            r_skid_v0    <= 1'b1;
          end else begin
            r_skid_data1 <= w_rd_word;
            r_skid_last1 <= w_issue_last;
            r_skid_v1    <= 1'b1;
          end
        end
        2'b10: begin
          r_skid_data0 <= r_skid_data1;
          r_skid_last0 <= r_skid_last1;
          r_skid_v0    <= r_skid_v1;
          r_skid_v1    <= 1'b0;
          r_skid_last1 <= 1'b0;
        end
        2'b11: begin
          r_skid_data0 <= w_rd_word;
          r_skid_last0 <= w_issue_last;
          r_skid_v0    <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_trig_q) begin
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        if (w_done) begin
          w_state_nxt = S_IDLE;
        end else if (w_overflow_evt) begin
          w_state_nxt = S_DUMMY;
        end
      end
      S_DUMMY: begin
        if (w_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_trig_dropped <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      r_trig_dropped <= w_trig_q && (r_state != S_IDLE);
      if (w_overflow_evt) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign DOUT             = r_skid_data0;
  assign DOUT_VALID       = r_skid_v0;
  assign DOUT_LAST        = r_skid_last0;
  assign BUSY             = (r_state != S_IDLE);
  assign BUFF_ALMOST_FULL = (r_state == S_READ) && (w_backlog >= PW'(AF_THR));
  assign TRIG_DROPPED     = r_trig_dropped;
  assign OVERFLOW         = r_overflow;
  assign DBG_STATE        = r_state;

endmodule
